// File: rtl/systolic_pkg.sv
// ---------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the systolic-array output path:
//   - wb_state_t : writeback FSM state encodings (IDLE / ACTIVE / DONE)
//   - clog2      : ceiling log2 for sizing pointers and counters
//   - calc_wpr   : SRAM words needed to carry one quantized row
// ---------------------------------------------------------------------------
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } wb_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int calc_wpr(input int lanes, input int lane_w, input int word_w);
    return (lanes * lane_w) / word_w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO, DEPTH entries of WIDTH bits, DEPTH a power of two.
// Read data is the current head (show-ahead); pop advances past it.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, wdata     write one entry (ignored when full)
//   pop, rdata      consume head entry (ignored when empty) / head entry
//   full, empty     occupancy flags
// ---------------------------------------------------------------------------
module sync_fifo
  import systolic_pkg::*;
#(
  parameter int WIDTH = 129,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/output_writeback.sv
// ---------------------------------------------------------------------------
// output_writeback
// Takes quantized rows (ARRAY_SIZE signed lanes) from the quantizer, buffers
// them in a small FIFO, serializes each row into SRAM_DATA_WIDTH words and
// writes them to consecutive SRAM addresses starting at a latched base.
// A one-cycle done pulse follows the last word of the tile.
//
// Optional build macro: RELU_EN -- when defined, negative lanes are clamped
// to zero before they enter the FIFO; otherwise lanes pass through unchanged.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          begin tile, latches base_addr (only honoured in IDLE)
//   base_addr      first SRAM word address of the tile
//   in_valid       row valid
//   in_ready       row accepted when in_valid & in_ready
//   in_data        row, lane i at [i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH]
//   in_last        marks the final row of the tile
//   sram_we        registered write strobe
//   sram_addr      registered write address (holds when idle)
//   sram_wdata     registered write data (holds when idle)
//   busy           high in ACTIVE and DONE
//   done           one-cycle pulse after the last word is written
// ---------------------------------------------------------------------------
module output_writeback
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE        = 8,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int SRAM_DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH        = 10,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [ADDR_WIDTH-1:0]                   base_addr,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] in_data,
  input  logic                                    in_last,
  output logic                                    sram_we,
  output logic [ADDR_WIDTH-1:0]                   sram_addr,
  output logic [SRAM_DATA_WIDTH-1:0]              sram_wdata,
  output logic                                    busy,
  output logic                                    done
);

  localparam int ROW_W = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
  localparam int WPR   = calc_wpr(ARRAY_SIZE, OUTPUT_DATA_WIDTH, SRAM_DATA_WIDTH);
  localparam int CW    = clog2(WPR) + 1;
  localparam int FW    = ROW_W + 1;

  // Lane conditioning applied on the way into the FIFO.
  function automatic logic [ROW_W-1:0] relu_row(input logic [ROW_W-1:0] r);
    logic [ROW_W-1:0] o;
    o = r;
`ifdef RELU_EN
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      logic signed [OUTPUT_DATA_WIDTH-1:0] lane;
      lane = r[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH];
      if (lane < 0) o[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] = '0;
    end
`endif
    return o;
  endfunction

  wb_state_t             state;
  logic                  last_seen;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [FW-1:0]         fifo_wdata;
  logic [FW-1:0]         fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ROW_W-1:0]      head_row;
  logic                  head_last;

  logic [ROW_W-1:0]      sh_row_p1;
  logic [CW-1:0]         sh_rem_p1;
  logic                  sh_last_p1;
  logic                  shift_emit;
  logic                  final_word;
  logic                  fin_p1;

  // No bypass: a full FIFO refuses a row even if it pops this cycle.
  assign in_ready   = (state == ST_ACTIVE) && !fifo_full && !last_seen;
  assign fifo_push  = in_valid && in_ready;
  assign fifo_wdata = {in_last, relu_row(in_data)};
  assign head_row   = fifo_rdata[ROW_W-1:0];
  assign head_last  = fifo_rdata[ROW_W];

  // A new row loads once the shifter has no words left, so the pop lands in
  // the cycle the previous row's final word is on the bus.
  assign fifo_pop   = (state == ST_ACTIVE) && (sh_rem_p1 == '0) && !fifo_empty;
  assign shift_emit = (state == ST_ACTIVE) && (sh_rem_p1 != '0);
  assign final_word = (shift_emit && (sh_rem_p1 == CW'(1)) && sh_last_p1) ||
                      (fifo_pop && (WPR == 1) && head_last);

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---- stage p1: FSM, address counter, registered SRAM write port ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      last_seen  <= 1'b0;
      addr_q     <= '0;
      sh_rem_p1  <= '0;
      sh_last_p1 <= 1'b0;
      fin_p1     <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      sram_we <= 1'b0;
      fin_p1  <= final_word;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_ACTIVE;
            addr_q    <= base_addr;
            last_seen <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          // fin_p1 is high while the tile's last word is on the bus.
          if (fin_p1) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase

      if (fifo_push && in_last) last_seen <= 1'b1;

      if (fifo_pop) begin
        sram_we    <= 1'b1;
        sram_wdata <= head_row[SRAM_DATA_WIDTH-1:0];
        sram_addr  <= addr_q;
        addr_q     <= addr_q + 1'b1;
        sh_rem_p1  <= CW'(WPR - 1);
        sh_last_p1 <= head_last;
      end else if (shift_emit) begin
        sram_we    <= 1'b1;
        sram_wdata <= sh_row_p1[SRAM_DATA_WIDTH-1:0];
        sram_addr  <= addr_q;
        addr_q     <= addr_q + 1'b1;
        sh_rem_p1  <= sh_rem_p1 - 1'b1;
      end
    end
  end

  // ---- stage p1: row shifter data (word 0 leaves directly from the FIFO head) ----
  always_ff @(posedge clk) begin
    if (fifo_pop) begin
      sh_row_p1 <= head_row >> SRAM_DATA_WIDTH;
    end else if (shift_emit) begin
      sh_row_p1 <= sh_row_p1 >> SRAM_DATA_WIDTH;
    end
  end

endmodule

// File: tb/tb_output_writeback.sv
// ---------------------------------------------------------------------------
// tb_output_writeback
// Directed bench for output_writeback. Accepted rows push their expected
// SRAM words (address + data) onto a scoreboard queue; every cycle with
// sram_we high pops and compares one entry. Honours RELU_EN when defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_output_writeback;

  localparam int AS  = 8;
  localparam int OW  = 16;
  localparam int SW  = 32;
  localparam int AW  = 10;
  localparam int RW  = AS * OW;
  localparam int WPR = RW / SW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          in_valid;
  logic          in_ready;
  logic [RW-1:0] in_data;
  logic          in_last;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [SW-1:0] sram_wdata;
  logic          busy;
  logic          done;

  output_writeback #(
    .ARRAY_SIZE        (AS),
    .OUTPUT_DATA_WIDTH (OW),
    .SRAM_DATA_WIDTH   (SW),
    .ADDR_WIDTH        (AW),
    .FIFO_DEPTH        (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int               checks   = 0;
  int               failures = 0;
  int               run      = 0;
  int               last_run = 0;
  logic [AW-1:0]    exp_addr;
  logic [AW+SW-1:0] sbq [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] model_row(input logic [RW-1:0] r);
    logic [RW-1:0] o;
    o = r;
`ifdef RELU_EN
    for (int i = 0; i < AS; i++) begin
      if (r[i*OW + OW - 1]) o[i*OW +: OW] = '0;
    end
`endif
    return o;
  endfunction

  function automatic logic [RW-1:0] mk_row(input int t, input int r);
    logic [RW-1:0] v;
    for (int i = 0; i < AS; i++) v[i*OW +: OW] = 16'((t << 12) | (r << 8) | (i * 3 + 1));
    return v;
  endfunction

  // Advance one cycle: record a handshake on the coming edge, then at the
  // following falling edge score any SRAM write on the bus.
  task automatic tick(output bit accepted);
    logic [RW-1:0]    mr;
    logic [AW+SW-1:0] e;
    #1;
    accepted = in_valid && in_ready;
    if (accepted) begin
      mr = model_row(in_data);
      for (int k = 0; k < WPR; k++) begin
        sbq.push_back({exp_addr, mr[k*SW +: SW]});
        exp_addr = exp_addr + 1'b1;
      end
    end
    @(negedge clk);
    if (sram_we) begin
      chk("sb_entry_avail", 64'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("wr_addr", 64'(sram_addr), 64'(e[AW+SW-1:SW]));
        chk("wr_data", 64'(sram_wdata), 64'(e[SW-1:0]));
      end
      run++;
    end else begin
      if (run != 0) last_run = run;
      run = 0;
    end
  endtask

  task automatic tk();
    bit a;
    tick(a);
  endtask

  task automatic wait_done(input string tag, input int limit);
    for (int i = 0; i < limit && !done; i++) tk();
    chk(tag, 64'(done), 1);
    tk();
    chk("sb_drained", 64'(sbq.size()), 0);
  endtask

  initial begin
    bit            a;
    int            sent;
    int            first_stall;
    int            extra;
    logic [RW-1:0] r5;
    logic [SW-1:0] w0_exp;
    logic [SW-1:0] w1_exp;

    rst = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0;
    in_data = '0; in_last = 1'b0; exp_addr = '0;

    // Power-on reset
    @(negedge clk);
    tk(); tk();
    chk("reset_we",    64'(sram_we), 0);
    chk("reset_busy",  64'(busy), 0);
    chk("reset_done",  64'(done), 0);
    chk("reset_ready", 64'(in_ready), 0);
    chk("reset_addr",  64'(sram_addr), 0);
    chk("reset_wdata", 64'(sram_wdata), 0);
    rst = 1'b0;
    tk();

    // Reset in the middle of a tile
    start = 1'b1; base_addr = 10'h050; exp_addr = 10'h050; tk(); start = 1'b0;
    in_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      in_data = mk_row(1, r);
      tick(a);
      chk("t1_accept", 64'(a), 1);
    end
    in_valid = 1'b0;
    tk(); tk();
    chk("t1_writing", 64'(sram_we), 1);
    rst = 1'b1;
    tk();
    chk("t1_rst_we",    64'(sram_we), 0);
    chk("t1_rst_busy",  64'(busy), 0);
    chk("t1_rst_done",  64'(done), 0);
    chk("t1_rst_ready", 64'(in_ready), 0);
    tk();
    sbq.delete();
    rst = 1'b0;
    repeat (8) tk();
    chk("t1_post_ready", 64'(in_ready), 0);
    chk("t1_post_busy",  64'(busy), 0);

    // Single row, latency and done timing
    start = 1'b1; base_addr = 10'h010; exp_addr = 10'h010; tk(); start = 1'b0;
    chk("t2_busy_active", 64'(busy), 1);
    in_valid = 1'b1; in_last = 1'b1;
    for (int i = 0; i < AS; i++) in_data[i*OW +: OW] = 16'(i + 1);
    tick(a);
    chk("t2_accept", 64'(a), 1);
    in_valid = 1'b0; in_last = 1'b0;
    chk("t2_we_t1", 64'(sram_we), 0);
    tk();
    chk("t2_first_we",   64'(sram_we), 1);
    chk("t2_first_addr", 64'(sram_addr), 64'h010);
    chk("t2_first_data", 64'(sram_wdata), 64'h0002_0001);
    tk(); tk(); tk();
    chk("t2_last_addr", 64'(sram_addr), 64'h013);
    chk("t2_last_data", 64'(sram_wdata), 64'h0008_0007);
    chk("t2_done_early", 64'(done), 0);
    tk();
    chk("t2_we_off",   64'(sram_we), 0);
    chk("t2_done",     64'(done), 1);
    chk("t2_busy_dn",  64'(busy), 1);
    chk("t2_run",      64'(last_run), 4);
    tk();
    chk("t2_done_pulse", 64'(done), 0);
    chk("t2_idle_busy",  64'(busy), 0);
    chk("t2_sb_empty",   64'(sbq.size()), 0);

    // Address wrap at the top of the SRAM
    start = 1'b1; base_addr = 10'h3FE; exp_addr = 10'h3FE; tk(); start = 1'b0;
    in_valid = 1'b1; in_data = mk_row(3, 0); in_last = 1'b0;
    tick(a);
    chk("t3_accept0", 64'(a), 1);
    in_data = mk_row(3, 1); in_last = 1'b1;
    tick(a);
    chk("t3_accept1", 64'(a), 1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_done("t3_done", 40);
    chk("t3_run", 64'(last_run), 8);
    chk("t3_addr_hold", 64'(sram_addr), 64'h005);

    // Eight rows with in_valid held high: back-pressure and no ninth row
    start = 1'b1; base_addr = 10'h100; exp_addr = 10'h100; tk(); start = 1'b0;
    sent = 0; first_stall = -1;
    in_valid = 1'b1; in_data = mk_row(4, 0); in_last = 1'b0;
    for (int g = 0; g < 120 && sent < 8; g++) begin
      if (!in_ready && first_stall < 0) first_stall = sent;
      tick(a);
      if (a) begin
        sent++;
        in_data = mk_row(4, sent);
        in_last = (sent == 7);
      end
    end
    chk("t4_sent", 64'(sent), 8);
    chk("t4_stall_at", 64'(first_stall), 5);
    in_last = 1'b0;
    extra = 0;
    repeat (12) begin
      tick(a);
      if (a) extra++;
    end
    chk("t4_no_ninth", 64'(extra), 0);
    in_valid = 1'b0;
    wait_done("t4_done", 100);
    chk("t4_run", 64'(last_run), 32);

    // Most-negative lane
    r5 = '0;
    r5[0*OW +: OW] = 16'h8000; r5[1*OW +: OW] = 16'h7FFF;
    r5[2*OW +: OW] = 16'hFFFF; r5[3*OW +: OW] = 16'h0001;
    r5[4*OW +: OW] = 16'h8001; r5[5*OW +: OW] = 16'h0000;
    r5[6*OW +: OW] = 16'h1234; r5[7*OW +: OW] = 16'hC000;
`ifdef RELU_EN
    w0_exp = 32'h7FFF_0000; w1_exp = 32'h0001_0000;
`else
    w0_exp = 32'h7FFF_8000; w1_exp = 32'h0001_FFFF;
`endif
    start = 1'b1; base_addr = 10'h020; exp_addr = 10'h020; tk(); start = 1'b0;
    in_valid = 1'b1; in_data = r5; in_last = 1'b1;
    tick(a);
    chk("t5_accept", 64'(a), 1);
    in_valid = 1'b0; in_last = 1'b0;
    tk();
    chk("t5_word0", 64'(sram_wdata), 64'(w0_exp));
    tk();
    chk("t5_word1", 64'(sram_wdata), 64'(w1_exp));
    wait_done("t5_done", 20);

    // start while ACTIVE is ignored
    start = 1'b1; base_addr = 10'h180; exp_addr = 10'h180; tk(); start = 1'b0;
    in_valid = 1'b1; in_data = mk_row(6, 0);
    tick(a);
    chk("t6_accept0", 64'(a), 1);
    start = 1'b1; base_addr = 10'h2AA; in_data = mk_row(6, 1);
    tick(a);
    chk("t6_accept1", 64'(a), 1);
    start = 1'b0; in_data = mk_row(6, 2); in_last = 1'b1;
    tick(a);
    chk("t6_accept2", 64'(a), 1);
    in_valid = 1'b0; in_last = 1'b0;
    wait_done("t6_done", 40);
    chk("t6_run", 64'(last_run), 12);
    chk("t6_addr_end", 64'(sram_addr), 64'h18B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
